equiv_miter_monitor: RTL and testbench

- Parametrised successor to the two-instance identity-check top: compares one golden output bus against NUM_DUT candidate buses every enabled clock.
- Aligns the golden stream with a configurable delay and masks a warm-up window after reset.
- Keeps sticky per-candidate failure flags, a saturating mismatch counter and a first-mismatch capture record.
- Sits beside the DUT instances inside each fuzz/equivalence proof top; the assert is driven from its registered fail output.

---
 rtl/equiv_miter_monitor.sv | 173 +++++++++++++++++
 tb/tb_equiv_miter_monitor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_miter_monitor.sv
// rtl/equiv_miter_monitor.sv - golden-vs-candidates miter with delay alignment, warm-up masking and first-mismatch capture
module equiv_miter_monitor #(
  parameter int WIDTH     = 91,
  parameter int NUM_DUT   = 2,
  parameter int REF_DELAY = 0,
  parameter int WARMUP    = 2,
  parameter int CNT_W     = 16,
  parameter int ASSERT_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         y_ref,
  input  logic [NUM_DUT*WIDTH-1:0] y_dut,
  output logic                     armed,
  output logic                     mismatch_now,
  output logic                     fail,
  output logic [NUM_DUT-1:0]       fail_mask,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         first_cycle,
  output logic [2:0]               first_idx,
  output logic [WIDTH-1:0]         first_ref,
  output logic [WIDTH-1:0]         first_dut
);

  localparam int WU_MAX = WARMUP + REF_DELAY;
  localparam int WU_W   = (WU_MAX > 0) ? $clog2(WU_MAX + 1) : 1;
  localparam logic [WU_W-1:0]  WU_INIT = WU_W'(WU_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]   ref_aligned;
  logic [NUM_DUT-1:0] diff;
  logic               any_diff;
  logic [2:0]         hit_idx;
  logic [WIDTH-1:0]   hit_dut;
  logic               valid;

  logic [WU_W-1:0]    wu_q, wu_d;
  logic               armed_q, armed_d;
  logic               mnow_q, mnow_d;
  logic [NUM_DUT-1:0] fmask_q, fmask_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   fcyc_q, fcyc_d;
  logic [2:0]         fidx_q, fidx_d;
  logic [WIDTH-1:0]   fref_q, fref_d;
  logic [WIDTH-1:0]   fdut_q, fdut_d;

  // The golden delay line only moves on enabled cycles so it stays in step with the candidates.
  if (REF_DELAY == 0) begin : g_nodly
    assign ref_aligned = y_ref;
  end else begin : g_dly
    logic [WIDTH-1:0] dl_q [REF_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < REF_DELAY; i++) dl_q[i] <= '0;
      end else if (en) begin
        dl_q[0] <= y_ref;
        for (int i = 1; i < REF_DELAY; i++) dl_q[i] <= dl_q[i-1];
      end
    end

    assign ref_aligned = dl_q[REF_DELAY-1];
  end

  always_comb begin
    diff = '0;
    for (int k = 0; k < NUM_DUT; k++) begin
      diff[k] = (y_dut[k*WIDTH +: WIDTH] != ref_aligned);
    end
  end

  // Scanning downward lets the lowest differing candidate win.
  always_comb begin
    hit_idx = '0;
    hit_dut = '0;
    for (int k = NUM_DUT - 1; k >= 0; k--) begin
      if (diff[k]) begin
        hit_idx = 3'(k);
        hit_dut = y_dut[k*WIDTH +: WIDTH];
      end
    end
  end

  assign any_diff = |diff;
  assign valid    = en && armed_q;

  always_comb begin
    wu_d    = wu_q;
    armed_d = armed_q;
    mnow_d  = 1'b0;
    fmask_d = fmask_q;
    mcnt_d  = mcnt_q;
    cyc_d   = cyc_q;
    fcyc_d  = fcyc_q;
    fidx_d  = fidx_q;
    fref_d  = fref_q;
    fdut_d  = fdut_q;

    if (clear) begin
      wu_d    = WU_INIT;
      armed_d = (WU_MAX == 0);
      fmask_d = '0;
      mcnt_d  = '0;
      cyc_d   = '0;
      fcyc_d  = '0;
      fidx_d  = '0;
      fref_d  = '0;
      fdut_d  = '0;
    end else if (en) begin
      if (wu_q != '0) wu_d = wu_q - 1'b1;
      armed_d = (wu_d == '0);
      if (cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
      if (valid && any_diff) begin
        mnow_d  = 1'b1;
        fmask_d = fmask_q | diff;
        if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + 1'b1;
        // Capture fields freeze once any candidate has failed.
        if (fmask_q == '0) begin
          fcyc_d = cyc_q;
          fidx_d = hit_idx;
          fref_d = ref_aligned;
          fdut_d = hit_dut;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wu_q    <= WU_INIT;
      armed_q <= 1'b0;
      mnow_q  <= 1'b0;
      fmask_q <= '0;
      mcnt_q  <= '0;
      cyc_q   <= '0;
      fcyc_q  <= '0;
      fidx_q  <= '0;
      fref_q  <= '0;
      fdut_q  <= '0;
    end else begin
      wu_q    <= wu_d;
      armed_q <= armed_d;
      mnow_q  <= mnow_d;
      fmask_q <= fmask_d;
      mcnt_q  <= mcnt_d;
      cyc_q   <= cyc_d;
      fcyc_q  <= fcyc_d;
      fidx_q  <= fidx_d;
      fref_q  <= fref_d;
      fdut_q  <= fdut_d;
    end
  end

  assign armed          = armed_q;
  assign mismatch_now   = mnow_q;
  assign fail_mask      = fmask_q;
  assign fail           = |fmask_q;
  assign mismatch_count = mcnt_q;
  assign cycle_count    = cyc_q;
  assign first_cycle    = fcyc_q;
  assign first_idx      = fidx_q;
  assign first_ref      = fref_q;
  assign first_dut      = fdut_q;

  if (ASSERT_EN != 0) begin : g_assert
    a_no_fail: assert property (@(posedge clk) disable iff (!rst_n) !fail);
  end

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// tb/tb_equiv_miter_monitor.sv - directed and randomized checks of equiv_miter_monitor against a behavioural model
module tb_equiv_miter_monitor;

  logic       clk;
  logic       rst_n;
  logic [1:0] en_v;
  logic [1:0] clr_v;
  logic [7:0]  yref_v [2];
  logic [23:0] ydut_v [2];

  logic [1:0]  armed_w, mnow_w, fail_w;
  logic [2:0]  fmask_w [2];
  logic [15:0] mcnt_w [2];
  logic [15:0] cyc_w [2];
  logic [15:0] fcyc_w [2];
  logic [2:0]  fidx_w [2];
  logic [7:0]  fref_w [2];
  logic [7:0]  fdut_w [2];

  logic [1:0]  fmask_a;
  logic [2:0]  fmask_b;
  logic [2:0]  mcnt_b, cyc_b, fcyc_b;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=8, 2 candidates, no delay, 16-bit counters.
  equiv_miter_monitor #(
    .WIDTH(8), .NUM_DUT(2), .REF_DELAY(0), .WARMUP(2), .CNT_W(16), .ASSERT_EN(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .clear(clr_v[0]),
    .y_ref(yref_v[0]), .y_dut(ydut_v[0][15:0]),
    .armed(armed_w[0]), .mismatch_now(mnow_w[0]), .fail(fail_w[0]),
    .fail_mask(fmask_a), .mismatch_count(mcnt_w[0]), .cycle_count(cyc_w[0]),
    .first_cycle(fcyc_w[0]), .first_idx(fidx_w[0]),
    .first_ref(fref_w[0]), .first_dut(fdut_w[0])
  );

  // Instance B: WIDTH=8, 3 candidates, delay 2, 3-bit counters.
  equiv_miter_monitor #(
    .WIDTH(8), .NUM_DUT(3), .REF_DELAY(2), .WARMUP(2), .CNT_W(3), .ASSERT_EN(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .clear(clr_v[1]),
    .y_ref(yref_v[1]), .y_dut(ydut_v[1]),
    .armed(armed_w[1]), .mismatch_now(mnow_w[1]), .fail(fail_w[1]),
    .fail_mask(fmask_b), .mismatch_count(mcnt_b), .cycle_count(cyc_b),
    .first_cycle(fcyc_b), .first_idx(fidx_w[1]),
    .first_ref(fref_w[1]), .first_dut(fdut_w[1])
  );

  assign fmask_w[0] = {1'b0, fmask_a};
  assign fmask_w[1] = fmask_b;
  assign mcnt_w[1]  = {13'd0, mcnt_b};
  assign cyc_w[1]   = {13'd0, cyc_b};
  assign fcyc_w[1]  = {13'd0, fcyc_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: configuration and state per instance.
  int P_D   [2] = '{0, 2};
  int P_WU  [2] = '{2, 2};
  int P_MAX [2] = '{65535, 7};
  int P_N   [2] = '{2, 3};

  int m_wu [2], m_cyc [2], m_mcnt [2], m_fmask [2], m_mnow [2];
  int m_fcyc [2], m_fidx [2], m_fref [2], m_fdut [2];
  logic [7:0] hist [2][8192];
  int nh [2];

  task automatic model_reset(input int i);
    m_wu[i] = P_WU[i] + P_D[i];
    m_cyc[i] = 0; m_mcnt[i] = 0; m_fmask[i] = 0; m_mnow[i] = 0;
    m_fcyc[i] = 0; m_fidx[i] = 0; m_fref[i] = 0; m_fdut[i] = 0;
    nh[i] = 0;
  endtask

  // Golden value REF_DELAY enabled samples back (zero before that many exist).
  function automatic logic [7:0] aligned(input int i, input logic [7:0] cur);
    if (P_D[i] == 0) return cur;
    if (nh[i] >= P_D[i]) return hist[i][nh[i] - P_D[i]];
    return 8'h00;
  endfunction

  task automatic model_step(input int i);
    logic [7:0] al;
    int diff;
    int fi;
    al = aligned(i, yref_v[i]);
    m_mnow[i] = 0;
    if (clr_v[i]) begin
      m_wu[i] = P_WU[i] + P_D[i];
      m_cyc[i] = 0; m_mcnt[i] = 0; m_fmask[i] = 0;
      m_fcyc[i] = 0; m_fidx[i] = 0; m_fref[i] = 0; m_fdut[i] = 0;
    end else if (en_v[i]) begin
      diff = 0;
      for (int k = 0; k < P_N[i]; k++)
        if (ydut_v[i][k*8 +: 8] != al) diff |= (1 << k);
      if (m_wu[i] == 0 && diff != 0) begin
        m_mnow[i] = 1;
        if (m_fmask[i] == 0) begin
          fi = -1;
          for (int k = 0; k < P_N[i]; k++)
            if (fi < 0 && diff[k]) fi = k;
          m_fcyc[i] = m_cyc[i];
          m_fidx[i] = fi;
          m_fref[i] = al;
          m_fdut[i] = ydut_v[i][fi*8 +: 8];
        end
        m_fmask[i] |= diff;
        if (m_mcnt[i] < P_MAX[i]) m_mcnt[i]++;
      end
      if (m_wu[i] > 0) m_wu[i]--;
      if (m_cyc[i] < P_MAX[i]) m_cyc[i]++;
    end
    if (en_v[i]) begin
      hist[i][nh[i]] = yref_v[i];
      nh[i]++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i);
    string p;
    p = (i == 0) ? "A" : "B";
    chk({p, ".armed"},     64'(armed_w[i]), 64'(m_wu[i] == 0));
    chk({p, ".mnow"},      64'(mnow_w[i]),  64'(m_mnow[i]));
    chk({p, ".fail"},      64'(fail_w[i]),  64'(m_fmask[i] != 0));
    chk({p, ".fail_mask"}, 64'(fmask_w[i]), 64'(m_fmask[i]));
    chk({p, ".mcnt"},      64'(mcnt_w[i]),  64'(m_mcnt[i]));
    chk({p, ".cyc"},       64'(cyc_w[i]),   64'(m_cyc[i]));
    chk({p, ".fcyc"},      64'(fcyc_w[i]),  64'(m_fcyc[i]));
    chk({p, ".fidx"},      64'(fidx_w[i]),  64'(m_fidx[i]));
    chk({p, ".fref"},      64'(fref_w[i]),  64'(m_fref[i]));
    chk({p, ".fdut"},      64'(fdut_w[i]),  64'(m_fdut[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic drive_a(input logic e, input logic c, input logic [7:0] r,
                         input logic [7:0] d0, input logic [7:0] d1);
    en_v[0] = e; clr_v[0] = c; yref_v[0] = r; ydut_v[0] = {8'h00, d1, d0};
  endtask

  task automatic drive_b(input logic e, input logic c, input logic [7:0] r, input logic [7:0] d);
    en_v[1] = e; clr_v[1] = c; yref_v[1] = r; ydut_v[1] = {d, d, d};
  endtask

  task automatic rand_inputs(input int i);
    logic [7:0] r, al;
    en_v[i]  = ($urandom_range(0, 3) != 0);
    clr_v[i] = en_v[i] && ($urandom_range(0, 49) == 0);
    r = 8'($urandom);
    yref_v[i] = r;
    al = aligned(i, r);
    for (int k = 0; k < 3; k++)
      ydut_v[i][k*8 +: 8] = ($urandom_range(0, 19) == 0) ? (al ^ 8'(1 << $urandom_range(0, 7))) : al;
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);
    model_reset(0);
    model_reset(1);
    #3;
    check_inst(0);
    check_inst(1);
    #4 rst_n = 1'b1;

    // Identical buses for 10 enabled cycles.
    for (int t = 1; t <= 10; t++) begin
      v = 8'($urandom);
      drive_a(1'b1, 1'b0, v, v, v);
      cycle();
      if (t == 2) chk("t1.armed_c2", 64'(armed_w[0]), 64'd1);
    end
    chk("t1.fail", 64'(fail_w[0]), 64'd0);
    chk("t1.mcnt", 64'(mcnt_w[0]), 64'd0);
    chk("t1.cyc",  64'(cyc_w[0]),  64'd10);

    // Single-candidate mismatch at enabled cycle 5 after a clear.
    drive_a(1'b1, 1'b1, 8'h11, 8'h11, 8'h11);
    cycle();
    for (int t = 1; t <= 4; t++) begin
      drive_a(1'b1, 1'b0, 8'(t), 8'(t), 8'(t));
      cycle();
    end
    drive_a(1'b1, 1'b0, 8'h3C, 8'h3C, 8'h3D);
    cycle();
    chk("t2.mnow",  64'(mnow_w[0]),  64'd1);
    chk("t2.fail",  64'(fail_w[0]),  64'd1);
    chk("t2.fmask", 64'(fmask_w[0]), 64'd2);
    chk("t2.fidx",  64'(fidx_w[0]),  64'd1);
    chk("t2.fref",  64'(fref_w[0]),  64'h3C);
    chk("t2.fdut",  64'(fdut_w[0]),  64'h3D);
    chk("t2.fcyc",  64'(fcyc_w[0]),  64'd4);

    // Tie on both candidates, then a later dut0-only mismatch.
    drive_a(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    cycle();
    for (int t = 0; t < 3; t++) begin
      drive_a(1'b1, 1'b0, 8'h40, 8'h40, 8'h40);
      cycle();
    end
    drive_a(1'b1, 1'b0, 8'h10, 8'h11, 8'h12);
    cycle();
    for (int t = 0; t < 2; t++) begin
      drive_a(1'b1, 1'b0, 8'h50, 8'h50, 8'h50);
      cycle();
    end
    drive_a(1'b1, 1'b0, 8'h20, 8'h21, 8'h20);
    cycle();
    chk("t3.fidx",  64'(fidx_w[0]),  64'd0);
    chk("t3.fref",  64'(fref_w[0]),  64'h10);
    chk("t3.fdut",  64'(fdut_w[0]),  64'h11);
    chk("t3.fcyc",  64'(fcyc_w[0]),  64'd3);
    chk("t3.mcnt",  64'(mcnt_w[0]),  64'd2);
    chk("t3.fmask", 64'(fmask_w[0]), 64'd3);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Delay-2 instance: candidates lag the golden ramp by two cycles.
    for (int t = 1; t <= 12; t++) begin
      drive_b(1'b1, 1'b0, 8'(t), (t > 2) ? 8'(t - 2) : 8'h00);
      cycle();
      if (t == 3) chk("t4.armed_c3", 64'(armed_w[1]), 64'd0);
      if (t == 4) chk("t4.armed_c4", 64'(armed_w[1]), 64'd1);
    end
    chk("t4.fail", 64'(fail_w[1]), 64'd0);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);

    // Warm-up mismatch ignored, then clear together with a mismatch.
    drive_a(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    cycle();
    drive_a(1'b1, 1'b0, 8'h01, 8'h02, 8'h03);
    cycle();
    chk("t5.warm_fail", 64'(fail_w[0]), 64'd0);
    drive_a(1'b1, 1'b0, 8'h07, 8'h07, 8'h07);
    cycle();
    drive_a(1'b1, 1'b1, 8'h01, 8'h02, 8'h03);
    cycle();
    chk("t5.fail",  64'(fail_w[0]),  64'd0);
    chk("t5.mnow",  64'(mnow_w[0]),  64'd0);
    chk("t5.mcnt",  64'(mcnt_w[0]),  64'd0);
    chk("t5.cyc",   64'(cyc_w[0]),   64'd0);
    chk("t5.armed", 64'(armed_w[0]), 64'd0);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // 3-bit counters saturate under a continuous mismatch.
    drive_b(1'b1, 1'b1, 8'h55, 8'hAA);
    cycle();
    for (int t = 0; t < 12; t++) begin
      drive_b(1'b1, 1'b0, 8'h55, 8'hAA);
      cycle();
    end
    chk("t6.mcnt", 64'(mcnt_w[1]), 64'd7);
    chk("t6.cyc",  64'(cyc_w[1]),  64'd7);
    chk("t6.fidx", 64'(fidx_w[1]), 64'd0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      rand_inputs(0);
      rand_inputs(1);
      cycle();
    end

    // Asynchronous reset pulse between clock edges.
    drive_a(1'b1, 1'b0, 8'h33, 8'h34, 8'h35);
    drive_b(1'b1, 1'b0, 8'h66, 8'h99);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_inst(0);
    check_inst(1);
    chk("rst.fail_b", 64'(fail_w[1]), 64'd0);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_inputs(0);
      rand_inputs(1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
